seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_scan_driver_if.sv | 22 ++
 rtl/seg7_scan_driver.sv | 130 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Bundle between a time source and the 4-digit MM:SS scan driver.
// Carries bcd_sl/sh/ml/mh digits and blank in; an, seg, dp out.
interface seg7_scan_driver_if;
   logic [3:0] bcd_sl;
   logic [3:0] bcd_sh;
   logic [3:0] bcd_ml;
   logic [3:0] bcd_mh;
   logic       blank;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   modport master (
      output bcd_sl, bcd_sh, bcd_ml, bcd_mh, blank,
      input  an, seg, dp
   );

   modport slave (
      input  bcd_sl, bcd_sh, bcd_ml, bcd_mh, blank,
      output an, seg, dp
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit 7-segment driver (MM:SS), active-low outputs.
// Ports: clk, reset (async, high), bus (slave: bcd_*/blank in; an/seg/dp out).
// Parameters: DIV clk cycles per digit slot, DEAD anode-off lead-in cycles.
// Define SEG7_LZB_EN to blank the minutes-high digit when it is zero.
module seg7_scan_driver #(
   parameter int DIV  = 1000,
   parameter int DEAD = 2
) (
   input logic              clk,
   input logic              reset,
   seg7_scan_driver_if.slave bus
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic          tick;
   logic          frame_end;

   logic [3:0] sh_sl;
   logic [3:0] sh_sh;
   logic [3:0] sh_ml;
   logic [3:0] sh_mh;

   logic [3:0] cur;
   logic       lit;
   logic [3:0] an_d;
   logic [6:0] seg_d;
   logic       dp_d;

   logic [3:0] an_q;
   logic [6:0] seg_q;
   logic       dp_q;

   assign tick      = (cnt == CNT_MAX);
   assign frame_end = tick && (idx == 2'd3);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
         idx <= 2'd0;
      end else if (tick) begin
         cnt <= '0;
         idx <= idx + 2'd1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Digits are latched only at the frame boundary so a frame
   // never mixes old and new time values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_sl <= 4'd0;
         sh_sh <= 4'd0;
         sh_ml <= 4'd0;
         sh_mh <= 4'd0;
      end else if (frame_end) begin
         sh_sl <= bus.bcd_sl;
         sh_sh <= bus.bcd_sh;
         sh_ml <= bus.bcd_ml;
         sh_mh <= bus.bcd_mh;
      end
   end

   always_comb begin
      cur = sh_sl;
      unique case (idx)
         2'd0: cur = sh_sl;
         2'd1: cur = sh_sh;
         2'd2: cur = sh_ml;
         2'd3: cur = sh_mh;
      endcase
   end

   always_comb begin
      lit = !bus.blank && (int'(cnt) >= DEAD);
`ifdef SEG7_LZB_EN
      if (idx == 2'd3 && sh_mh == 4'd0) begin
         lit = 1'b0;
      end
`endif
   end

   always_comb begin
      an_d = 4'b1111;
      if (lit) begin
         an_d[idx] = 1'b0;
      end
   end

   always_comb begin
      seg_d = 7'b0111111;
      case (cur)
         4'd0:    seg_d = 7'b1000000;
         4'd1:    seg_d = 7'b1111001;
         4'd2:    seg_d = 7'b0100100;
         4'd3:    seg_d = 7'b0110000;
         4'd4:    seg_d = 7'b0011001;
         4'd5:    seg_d = 7'b0010010;
         4'd6:    seg_d = 7'b0000010;
         4'd7:    seg_d = 7'b1111000;
         4'd8:    seg_d = 7'b0000000;
         4'd9:    seg_d = 7'b0010000;
         default: seg_d = 7'b0111111;
      endcase
   end

   // Colon sits with the minutes-low digit and follows its anode.
   assign dp_d = !(lit && (idx == 2'd2));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an_q  <= 4'b1111;
         seg_q <= 7'b1111111;
         dp_q  <= 1'b1;
      end else begin
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign bus.an  = an_q;
   assign bus.seg = seg_q;
   assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with DIV=4, DEAD=1.
// Stimulus pushes expected outputs; a monitor pops and compares.
module tb_seg7_scan_driver;

   localparam int DIV  = 4;
   localparam int DEAD = 1;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   logic clk;
   logic reset;

   seg7_scan_driver_if bus ();

   seg7_scan_driver #(
      .DIV  (DIV),
      .DEAD (DEAD)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Model: cycles elapsed since reset release plus frame-latched digits.
   int   m_t;
   int   m_sh[4];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] glyph(int v);
      case (v)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   function automatic exp_t predict(int t, bit blk);
      exp_t e;
      int   slot;
      int   digit;
      int   v;
      bit   on;
      slot  = t % DIV;
      digit = (t / DIV) % 4;
      v     = m_sh[digit];
      on    = !blk && (slot >= DEAD);
`ifdef SEG7_LZB_EN
      if (digit == 3 && v == 0) on = 0;
`endif
      e.an = 4'b1111;
      if (on) e.an[digit] = 1'b0;
      e.seg = glyph(v);
      e.dp  = !(on && digit == 2);
      return e;
   endfunction

   task automatic step(int sl, int sh, int ml, int mh, bit blk);
      @(negedge clk);
      bus.bcd_sl = 4'(sl);
      bus.bcd_sh = 4'(sh);
      bus.bcd_ml = 4'(ml);
      bus.bcd_mh = 4'(mh);
      bus.blank  = blk;
      q.push_back(predict(m_t, blk));
      if ((m_t % DIV) == DIV - 1 && ((m_t / DIV) % 4) == 3) begin
         m_sh[0] = sl;
         m_sh[1] = sh;
         m_sh[2] = ml;
         m_sh[3] = mh;
      end
      m_t++;
   endtask

   task automatic run(int n, int sl, int sh, int ml, int mh, bit blk);
      for (int i = 0; i < n; i++) step(sl, sh, ml, mh, blk);
   endtask

   task automatic check_idle(string name);
      n_cmp++;
      if (bus.an !== 4'b1111 || bus.seg !== 7'b1111111 || bus.dp !== 1'b1) begin
         n_bad++;
         $display("FAIL %s: got an=%b seg=%b dp=%b want an=1111 seg=1111111 dp=1",
                  name, bus.an, bus.seg, bus.dp);
      end
   endtask

   // Asynchronous reset mid-slot, checked before any clock edge.
   task automatic do_reset();
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check_idle("async_reset");
      repeat (3) @(posedge clk);
      #1;
      check_idle("held_reset");
      @(posedge clk);
      #3;
      reset = 1'b0;
      m_t = 0;
      for (int i = 0; i < 4; i++) m_sh[i] = 0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if (bus.an !== e.an || bus.seg !== e.seg || bus.dp !== e.dp) begin
               n_bad++;
               $display("FAIL scan t=%0t: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                        $time, bus.an, bus.seg, bus.dp, e.an, e.seg, e.dp);
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      reset      = 1'b1;
      bus.bcd_sl = 4'd0;
      bus.bcd_sh = 4'd0;
      bus.bcd_ml = 4'd0;
      bus.bcd_mh = 4'd0;
      bus.blank  = 1'b0;
      m_t = 0;
      for (int i = 0; i < 4; i++) m_sh[i] = 0;
      #2;
      check_idle("reset_no_clk");
      do_reset();

      run(48, 1, 2, 3, 4, 0);
      run(20, 5, 2, 3, 4, 0);
      run(40, 7, 2, 3, 4, 0);
      run(40, 7, 5, 4'hC, 1, 0);
      run(6, 7, 5, 4, 1, 0);
      run(32, 7, 5, 4, 1, 1);
      run(26, 7, 5, 4, 1, 0);
      run(48, 9, 5, 9, 0, 0);
      run(40, 8, 0, 15, 0, 0);

      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 15),
              ($urandom_range(0, 7) == 0));
      end

      @(posedge clk);
      #2;
      do_reset();
      run(20, 6, 3, 2, 1, 0);
      for (int i = 0; i < 80; i++) begin
         step($urandom_range(0, 9), $urandom_range(0, 5),
              $urandom_range(0, 9), $urandom_range(0, 5), 0);
      end

      @(posedge clk);
      #2;
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
